// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters feeding one registered
// output stage that carries sync, blanking, raster position and frame number.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   CW       = 10
) (
    input  logic          pixel_clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          sync_rst,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x_count,
    output logic [CW-1:0] y_count,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // Region bounds carry one extra bit: a sync end can equal 2^CW when the porch is zero.
    localparam logic [CW:0] H_DE_END = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] H_SY_BEG = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] H_SY_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] V_DE_END = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] V_SY_BEG = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] V_SY_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] r_hc;
    logic [CW-1:0] r_vc;
    logic [7:0]    r_frame_num;

    logic [CW-1:0] w_hc_next;
    logic [CW-1:0] w_vc_next;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_de_act;
    logic          w_at_line;
    logic          w_at_origin;

    always_comb begin
        w_h_last    = (r_hc == H_LAST);
        w_v_last    = (r_vc == V_LAST);
        w_hc_next   = w_h_last ? '0 : r_hc + CW'(1);
        w_vc_next   = w_v_last ? '0 : r_vc + CW'(1);
        w_hs_act    = ({1'b0, r_hc} >= H_SY_BEG) && ({1'b0, r_hc} < H_SY_END);
        w_vs_act    = ({1'b0, r_vc} >= V_SY_BEG) && ({1'b0, r_vc} < V_SY_END);
        w_de_act    = ({1'b0, r_hc} < H_DE_END) && ({1'b0, r_vc} < V_DE_END);
        w_at_line   = (r_hc == '0);
        w_at_origin = w_at_line && (r_vc == '0);
    end

    // Restart wins over a simultaneous frame wrap, so the frame number never bumps on it.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hc        <= '0;
            r_vc        <= '0;
            r_frame_num <= '0;
        end else if (sync_rst) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (en) begin
            r_hc <= w_hc_next;
            if (w_h_last) begin
                r_vc <= w_vc_next;
                if (w_v_last) begin
                    r_frame_num <= r_frame_num + 8'd1;
                end
            end
        end
    end

    // Output stage samples the pre-advance counters; pulses are re-evaluated every edge.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_count     <= '0;
            y_count     <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            line_start  <= en & w_at_line;
            frame_start <= en & w_at_origin;
            if (en) begin
                x_count     <= r_hc;
                y_count     <= r_vc;
                hsync       <= w_hs_act ? HS_POL : ~HS_POL;
                vsync       <= w_vs_act ? VS_POL : ~VS_POL;
                de          <= w_de_act;
                frame_count <= r_frame_num;
            end
        end
    end

endmodule
